// File: rtl/y_trim_pkg.sv
// ============================================================================
// Module : y_trim_pkg
// Brief  : Shared constants, FSM encoding and tuser rewrite helper for y_trim.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y_trim_pkg;

  localparam int unsigned TDATA_W   = 64;
  localparam int unsigned TUSER_W   = 4;

  localparam int unsigned TUSER_SOF = 0;
  localparam int unsigned TUSER_EOF = 1;
  localparam int unsigned TUSER_SOL = 2;
  localparam int unsigned TUSER_EOL = 3;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ROW_KEEP = 2'd1,
    ROW_DROP = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  // Start flag on the first beat, end flag on the last; a single-beat row gets both.
  function automatic logic [TUSER_W-1:0] rewrite_tuser(
    input logic first_beat,
    input logic last_beat,
    input logic first_row,
    input logic final_row
  );
    logic [TUSER_W-1:0] u;
    u = '0;
    if (first_beat) u[first_row ? TUSER_SOF : TUSER_SOL] = 1'b1;
    if (last_beat)  u[final_row ? TUSER_EOF : TUSER_EOL] = 1'b1;
    return u;
  endfunction

endpackage

`default_nettype wire

// File: rtl/y_trim_axis_reg_slice.sv
// ============================================================================
// Module : axis_reg_slice
// Brief  : Single-stage AXI-Stream output register with valid/ready.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_reg_slice #(
  parameter int DATA_W = 69
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign s_ready_o = !valid_q | m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (s_valid_i && s_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= s_data_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/y_trim.sv
// ============================================================================
// Module : y_trim
// Brief  : Vertical ROI / row-subsampling stage with sync-flag rewrite.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y_trim
  import y_trim_pkg::*;
#(
  parameter int Y_WIDTH = 13
) (
  input  logic               bclk,
  input  logic               bclk_reset,
  input  logic               bclk_y_crop_en,
  input  logic [Y_WIDTH-1:0] bclk_y_start,
  input  logic [Y_WIDTH-1:0] bclk_y_size,
  input  logic [3:0]         bclk_y_scale,
  input  logic               bclk_s_tvalid,
  output logic               bclk_s_tready,
  input  logic [TDATA_W-1:0] bclk_s_tdata,
  input  logic [TUSER_W-1:0] bclk_s_tuser,
  input  logic               bclk_s_tlast,
  output logic               bclk_m_tvalid,
  input  logic               bclk_m_tready,
  output logic [TDATA_W-1:0] bclk_m_tdata,
  output logic [TUSER_W-1:0] bclk_m_tuser,
  output logic               bclk_m_tlast,
  output logic               bclk_frame_error
);

  localparam int YW1    = Y_WIDTH + 1;
  localparam int BEAT_W = TDATA_W + TUSER_W + 1;

  state_e             state_q;
  logic               crop_q;
  logic [Y_WIDTH-1:0] start_q;
  logic [Y_WIDTH-1:0] size_q;
  logic [3:0]         scale_q;
  logic [Y_WIDTH:0]   last_keep_q;
  logic [Y_WIDTH-1:0] row_q;
  logic [3:0]         sub_q;
  logic               in_win_q;
  logic               first_beat_q;
  logic               kept_any_q;
  logic               frame_error_q;

  logic               w_sof;
  logic               w_eof;
  logic               w_crop;
  logic [Y_WIDTH-1:0] w_start;
  logic [Y_WIDTH-1:0] w_size;
  logic [3:0]         w_scale;
  logic [Y_WIDTH:0]   w_stop;
  logic [Y_WIDTH:0]   w_lk_step;
  logic [Y_WIDTH:0]   w_lk_num;
  logic [Y_WIDTH:0]   w_lk_in;
  logic [Y_WIDTH:0]   w_last_keep;
  logic [Y_WIDTH-1:0] w_row;
  logic [Y_WIDTH-1:0] w_row_nx;
  logic               w_row0_in_win;
  logic               w_cur_in_win;
  logic [3:0]         w_cur_sub;
  logic               w_nx_in_win;
  logic [3:0]         w_nx_sub;
  logic               w_nx_keep;
  state_e             w_state;
  state_e             w_nx_row_state;
  logic               w_keep_beat;
  logic               w_slice_ready;
  logic               w_acc;
  logic               w_push;
  logic               w_is_last_keep;
  logic               w_final_row;
  logic               w_first_beat;
  logic               w_first_row;
  logic [TUSER_W-1:0] w_tuser;
  logic [BEAT_W-1:0]  w_m_beat;
  logic               w_unused;

  // A SOF beat belongs to the new frame: it sees the live config and row 0.
  assign w_sof   = bclk_s_tvalid & bclk_s_tuser[TUSER_SOF];
  assign w_eof   = bclk_s_tuser[TUSER_EOF];
  assign w_crop  = w_sof ? bclk_y_crop_en : crop_q;
  assign w_start = w_sof ? bclk_y_start   : start_q;
  assign w_size  = w_sof ? bclk_y_size    : size_q;
  assign w_scale = w_sof ? bclk_y_scale   : scale_q;

  assign w_stop    = {1'b0, w_start} + {1'b0, w_size} - YW1'(1);
  assign w_lk_step = YW1'(bclk_y_scale) + YW1'(1);
  assign w_lk_num  = {1'b0, bclk_y_size} - YW1'(1);
  assign w_lk_in   = {1'b0, bclk_y_start} + (w_lk_num / w_lk_step) * w_lk_step;
  assign w_last_keep = w_sof ? w_lk_in : last_keep_q;

  assign w_row    = w_sof ? '0 : row_q;
  assign w_row_nx = w_row + 1'b1;

  assign w_row0_in_win = !bclk_y_crop_en | ((bclk_y_size != '0) & (bclk_y_start == '0));
  assign w_cur_in_win  = w_sof ? w_row0_in_win : in_win_q;
  assign w_cur_sub     = w_sof ? 4'd0 : sub_q;

  assign w_nx_in_win = !w_crop | ((w_size != '0) & (w_row_nx >= w_start) &
                                  ({1'b0, w_row_nx} <= w_stop));
  // The subsample phase restarts on the first in-window row of the frame.
  assign w_nx_sub  = (!w_cur_in_win || (w_cur_sub == w_scale)) ? 4'd0 : w_cur_sub + 4'd1;
  assign w_nx_keep = w_nx_in_win & (w_nx_sub == 4'd0);
  assign w_nx_row_state = w_nx_keep ? ROW_KEEP : ROW_DROP;

  assign w_state     = w_sof ? (w_row0_in_win ? ROW_KEEP : ROW_DROP) : state_q;
  assign w_keep_beat = (w_state == ROW_KEEP);

  assign bclk_s_tready = !bclk_reset & (!w_keep_beat | w_slice_ready);
  assign w_acc         = bclk_s_tvalid & bclk_s_tready;
  assign w_push        = w_acc & w_keep_beat;

  assign w_is_last_keep = w_crop & (w_size != '0) & ({1'b0, w_row} == w_last_keep);
  assign w_final_row    = w_is_last_keep | w_eof;
  assign w_first_beat   = w_sof | first_beat_q;
  assign w_first_row    = w_sof | !kept_any_q;
  assign w_tuser        = rewrite_tuser(w_first_beat, bclk_s_tlast, w_first_row, w_final_row);

  assign w_unused = ^bclk_s_tuser[TUSER_EOL:TUSER_SOL];

  always_ff @(posedge bclk or posedge bclk_reset) begin
    if (bclk_reset) begin
      state_q       <= WAIT_SOF;
      crop_q        <= 1'b0;
      start_q       <= '0;
      size_q        <= '0;
      scale_q       <= '0;
      last_keep_q   <= '0;
      row_q         <= '0;
      sub_q         <= '0;
      in_win_q      <= 1'b0;
      first_beat_q  <= 1'b1;
      kept_any_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      if (w_acc) begin
        if (w_sof) begin
          crop_q      <= bclk_y_crop_en;
          start_q     <= bclk_y_start;
          size_q      <= bclk_y_size;
          scale_q     <= bclk_y_scale;
          last_keep_q <= w_lk_in;
          if (state_q != WAIT_SOF) frame_error_q <= 1'b1;
        end
        row_q        <= bclk_s_tlast ? w_row_nx : w_row;
        first_beat_q <= bclk_s_tlast;
        if (w_keep_beat)  kept_any_q <= 1'b1;
        else if (w_sof)   kept_any_q <= 1'b0;
        if (bclk_s_tlast) begin
          in_win_q <= w_nx_in_win;
          sub_q    <= w_nx_sub;
        end else begin
          in_win_q <= w_cur_in_win;
          sub_q    <= w_cur_sub;
        end

        unique case (w_state)
          WAIT_SOF: state_q <= WAIT_SOF;
          ROW_KEEP: begin
            if (!bclk_s_tlast)       state_q <= ROW_KEEP;
            else if (w_eof)          state_q <= WAIT_SOF;
            else if (w_is_last_keep) state_q <= DRAIN;
            else                     state_q <= w_nx_row_state;
          end
          ROW_DROP: begin
            if (!bclk_s_tlast) begin
              state_q <= ROW_DROP;
            end else if (w_eof) begin
              state_q <= WAIT_SOF;
              // Frame ended after kept rows but before any EOF was emitted.
              if (!w_sof && kept_any_q) frame_error_q <= 1'b1;
            end else begin
              state_q <= w_nx_row_state;
            end
          end
          DRAIN: state_q <= w_eof ? WAIT_SOF : DRAIN;
        endcase
      end
    end
  end

  axis_reg_slice #(
    .DATA_W (BEAT_W)
  ) u_out_slice (
    .clk_i     (bclk),
    .rst_i     (bclk_reset),
    .s_valid_i (w_push),
    .s_ready_o (w_slice_ready),
    .s_data_i  ({bclk_s_tdata, w_tuser, bclk_s_tlast}),
    .m_valid_o (bclk_m_tvalid),
    .m_ready_i (bclk_m_tready),
    .m_data_o  (w_m_beat)
  );

  assign bclk_m_tdata     = w_m_beat[BEAT_W-1 -: TDATA_W];
  assign bclk_m_tuser     = w_m_beat[TUSER_W:1];
  assign bclk_m_tlast     = w_m_beat[0];
  assign bclk_frame_error = frame_error_q;

endmodule

`default_nettype wire

// File: doc/y_trim.md
# y_trim

Vertical region-of-interest and row-subsampling stage on the `bclk` AXI-Stream pixel path, directly downstream of `x_trim`. It consumes the 64-bit row stream that `x_trim` produces, keeps only rows inside the programmed Y window and subsampling grid, and drops all other rows at full rate. It rewrites the sync flags in `tuser` so the output is a well-formed frame: SOF on the first kept row, EOF on the last kept row, SOL/EOL on the rows in between.

## Interface
- `Y_WIDTH`, 13, width of row counter and Y configuration fields.
- `bclk`  in  1  pixel clock; all logic on rising edge.
- `bclk_reset`  in  1  reset, asynchronous, active-high.
- `bclk_y_crop_en`  in  1  1 = apply Y window; 0 = window is rows 0..2^Y_WIDTH-1.
- `bclk_y_start`  in  Y_WIDTH  first row of window.
- `bclk_y_size`  in  Y_WIDTH  window height in rows; 0 = no rows kept.
- `bclk_y_scale`  in  4  keep 1 row out of (scale+1).
- `bclk_s_tvalid` / `bclk_s_tready`  in / out  1  input handshake.
- `bclk_s_tdata`  in  64  pixel beat.
- `bclk_s_tuser`  in  4  bit0 SOF, bit1 EOF, bit2 SOL, bit3 EOL.
- `bclk_s_tlast`  in  1  last beat of row.
- `bclk_m_tvalid` / `bclk_m_tready`  out / in  1  output handshake.
- `bclk_m_tdata` / `bclk_m_tuser` / `bclk_m_tlast`  out  64 / 4 / 1  output beat, same encoding.
- `bclk_frame_error`  out  1  one-cycle pulse on protocol anomaly.

## Operation
- **Configuration latch.** Configuration is sampled into shadow registers on the accepted SOF beat. Changes mid-frame have no effect until the next SOF.
- **Window.** `y_stop = y_start + y_size - 1`, computed at Y_WIDTH+1 bits with no wrap. A row r is in the window if `y_start <= r <= y_stop`.
- **Subsampling.** A subsample counter resets to 0 on the first in-window row and counts 0..scale, wrapping to 0. A row is kept when it is in the window and the counter is 0.
- **Last kept row.** `last_keep = y_start + ((y_size-1) / (scale+1)) * (scale+1)`. It is computed at SOF as a multicycle-free constant from the shadow registers. When crop is disabled, `last_keep` is undefined and EOF comes only from the input.
- **Row counter.** Increments on each accepted `s_tlast`. It is cleared by SOF.
- **FSM states.**
  - WAIT_SOF: input beats are consumed and discarded. An accepted beat with tuser[0] goes to ROW_KEEP or ROW_DROP for row 0.
  - ROW_KEEP: beats are forwarded. On accepted tlast:
    - if the row was last_keep or carried input EOF, go to DRAIN (or to WAIT_SOF if input EOF is on this beat);
    - otherwise decide the next row.
  - ROW_DROP: `s_tready = 1` and beats are discarded. On tlast with input EOF, go to WAIT_SOF. If a kept row was already emitted without EOF, pulse `bclk_frame_error`.
  - DRAIN: discard until input EOF, then go to WAIT_SOF.
- **tuser rewrite.**
  - First beat of the first kept row: 0001.
  - First beat of other kept rows: 0100.
  - Last beat of the final kept row: 0010.
  - Last beat of other kept rows: 1000.
  - Single-beat row: start and end bits are ORed.
  - Middle beats: 0000.
  - `m_tlast` equals input tlast.
- **tdata.** Passes through unmodified.
- **y_size = 0 with crop enabled.** The whole frame is dropped with no error.
- **SOF while not in WAIT_SOF.** The block pulses `bclk_frame_error`, restarts the frame from that beat and reloads configuration. No artificial tlast is inserted.

## Timing
- **Reset.** While `bclk_reset` is high, all outputs are 0: `m_tvalid`, `m_tdata`, `m_tuser`, `m_tlast`, `frame_error` and `s_tready`. The FSM is in WAIT_SOF and the counters are 0.
- **Output register.** A single output register stage gives 1-cycle latency from an accepted input beat to `m_tvalid`.
- **Ready.**
  - In ROW_KEEP: `s_tready = !m_tvalid | m_tready`, combinational from `m_tready`.
  - In WAIT_SOF, ROW_DROP and DRAIN: `s_tready = 1`.
- **Output hold.** While `m_tvalid & !m_tready`, the output holds stable (AXI rule) and no input is accepted in ROW_KEEP.
- **Throughput.** One beat per cycle when `m_tready` stays high. Dropped rows never stall on `m_tready`.
- **Row boundary.** The keep/drop decision for row r+1 is registered on the tlast of row r, so there are no bubbles at row boundaries.

## Structure
- Shared package `y_trim_pkg`:
  - tuser bit index constants SOF=0, EOF=1, SOL=2, EOL=3;
  - FSM enum `{WAIT_SOF, ROW_KEEP, ROW_DROP, DRAIN}`.
  - The `x_trim` test environment reuses the same constants.
- One sub-module, `axis_reg_slice`: the 64+4+1-bit output register with valid/ready.
- The FSM, counters and flag rewrite live in the top module.

## Test plan
- **Crop disabled, scale 0.** Frame of 8 rows × 16 beats with a ramp pattern -> output is byte-identical to input, SOF on row 0 beat 0, EOF on row 7 beat 15.
- **Crop enabled, start 2, size 3.** Same 8-row frame -> rows 2, 3 and 4 are output; row 2 beat 0 tuser=0001; row 4 beat 15 tuser=0010; rows 0–1 and 5–7 are absent; `frame_error` never pulses.
- **Crop enabled, start 1, size 6, scale 1.** Same 8-row frame -> rows 1, 3 and 5 are output, last_keep=5 carries EOF, and rows 6–7 are drained.
- **Backpressure.** Case 2 with `m_tready` low every 3rd cycle -> no beat is lost or duplicated, the output holds stable while stalled, and the dropped rows still consume at 1 beat/cycle.
- **Truncated frame.** Crop disabled, scale 1, 7-row frame -> rows 0, 2, 4 and 6 are output and row 6 carries EOF. A 6-row frame -> rows 0, 2 and 4 are output, and `frame_error` pulses when the dropped row 5 carries EOF.
- **Reset mid-row and stray SOF.** Assert reset mid-row -> outputs are 0 immediately. A second SOF injected at row 3 of a frame -> `frame_error` pulses and the output restarts with a SOF beat.
